imm_encoder: RTL and testbench
==============================

# imm_encoder

Packs a signed immediate into the RV64I immediate fields of a 32-bit instruction template, checks that the value fits, and streams the finished instruction words out through a registered valid/ready port. It is the inverse of the decode-stage immediate extraction. It also expands an "LI" request into a LUI+ADDIW pair (or a single LUI or ADDI) for 32-bit signed constants. It is used by the boot-ROM/self-test instruction generator and as the stimulus source for decode verification.

## Interface
- DATA_WIDTH, 64, width of the immediate input.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted this cycle when high together with req_valid_i.
- req_kind_i  in  3  immediate format, imm_kind_e: I=0, S=1, B=2, J=3, U=4, LI=5; 6 and 7 are illegal.
- req_tmpl_i  in  32  instruction template (opcode, rd, rs1, rs2, funct3, funct7); immediate bit positions are ignored and overwritten. For LI, only bits [11:7] (rd) are used.
- req_imm_i  in  DATA_WIDTH  signed immediate value.
- inst_valid_o  out  1  output word valid.
- inst_ready_i  in  1  downstream ready.
- inst_o  out  32  encoded instruction.
- inst_last_o  out  1  this is the final word for the current request.
- err_o  out  1  range or alignment violation for this request; held with every word of the request.

## Operation
- Field packing for I, S, B, J and U uses the standard RV32/64 bit scatter. B and J drop imm[0]. U places imm[31:12] at [31:12].
- Range checks; err_o=1 when any check fails:
  - I, S: imm must sign-fit in 12 bits.
  - B: imm must sign-fit in 13 bits and imm[0]=0.
  - J: imm must sign-fit in 21 bits and imm[0]=0.
  - U: imm must sign-fit in 32 bits and imm[11:0]=0.
  - LI: imm must sign-fit in 32 bits.
  - Illegal kind: err_o=1 and inst_o=req_tmpl_i.
- On error the truncated bits are still packed. The word is emitted, never dropped.
- LI expansion: lo12=imm[11:0]; hi20=(imm[31:0]+32'h800)[31:12], with the 32-bit sum wrapping.
  - hi20==0: emit one word, ADDI rd,x0,lo12 (opcode 7'h13, funct3 0).
  - lo12==0 and hi20!=0: emit one word, LUI rd,hi20 (opcode 7'h37).
  - Otherwise emit LUI rd,hi20 (inst_last_o=0), then ADDIW rd,rd,lo12 (opcode 7'h1b, funct3 0, rs1=rd; inst_last_o=1).
- FSM, one output register:
  - S_IDLE: output empty.
  - S_OUT: output holds the final word.
  - S_LI1: output holds the LUI word; the ADDIW word is pending in a side register.
- Transitions:
  - S_IDLE: accept a request, then go to S_LI1 (two-word LI) or to S_OUT.
  - S_OUT: on handshake with a new accept, reload and go to S_OUT or S_LI1. On handshake with no accept, go to S_IDLE.
  - S_LI1: on handshake, load ADDIW and go to S_OUT. No request is accepted in S_LI1.
- req_ready_o = (state==S_IDLE) | (state==S_OUT & inst_ready_i). This is combinational from inst_ready_i.
- While inst_valid_o=1 and inst_ready_i=0, inst_o, inst_last_o and err_o hold stable.

## Timing
- Latency: a request accepted at edge N appears on inst_o after edge N, so it is visible in cycle N+1.
- Throughput: 1 word/cycle for single-word requests; a two-word LI blocks new requests for 1 extra cycle.
- Reset: inst_valid_o=0, inst_o=0, inst_last_o=0, err_o=0, state=S_IDLE, so req_ready_o=1 after reset.
- Reset while in S_LI1 or S_OUT discards the held and pending words; there is no partial output after reset.
- A request whose req_valid_i is dropped before acceptance has no effect.

## Structure
- The shared package holds:
  - imm_kind_e;
  - opcode constants OP_IMM=7'h13, OP_IMM32=7'h1b, LOAD=7'h03, STORE=7'h23, BRANCH=7'h63, JALR=7'h67, JAL=7'h6f, AUIPC=7'h17, LUI=7'h37;
  - the state enum.
- Sub-module imm_pack is purely combinational. It takes (kind, tmpl, imm) and returns (word0, word1, two_words, err). imm_encoder wraps it with the FSM and registers.

## Test plan
- I-type, tmpl=32'h00000013, imm=-1 → inst_o=32'hfff00013, err_o=0, inst_last_o=1, one cycle after accept.
- B-type, tmpl=32'h00000063, imm=13'h1000 (-4096) → inst_o=32'h80000063; imm=3 → err_o=1 (odd offset).
- LI, rd=x5, imm=32'h7ffff800 → LUI word 32'h800002b7, then ADDIW word 32'h8002829b with inst_last_o=1. The bench's golden decode must return 64'h000000007ffff800.
- LI, rd=x1, imm=5 → single word 32'h00500093; imm=32'h12345000 → single word 32'h123450b7.
- Backpressure: hold inst_ready_i=0 for 3 cycles during S_LI1 → LUI word stable and req_ready_o=0 throughout; then inst_ready_i=1 → ADDIW follows the next cycle.
- Reset asserted in S_LI1 → after the reset cycle inst_valid_o=0 and req_ready_o=1; the ADDIW word is never emitted.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// -----------------------------------------------------------------------------
// imm_encoder_pkg
// Shared definitions for the immediate encoder slice:
//   - imm_kind_e : immediate format selector (I, S, B, J, U, LI; 6/7 illegal)
//   - RV64I major opcode constants used when building LI expansions
//   - state_e    : output FSM states of imm_encoder
//   - fits_signed: true when a 64-bit value is representable as an N-bit
//                  two's-complement number
// -----------------------------------------------------------------------------
package imm_encoder_pkg;

    typedef enum logic [2:0] {
        IMM_I  = 3'd0,
        IMM_S  = 3'd1,
        IMM_B  = 3'd2,
        IMM_J  = 3'd3,
        IMM_U  = 3'd4,
        IMM_LI = 3'd5
    } imm_kind_e;

    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_IMM32 = 7'h1b;
    localparam logic [6:0] LOAD     = 7'h03;
    localparam logic [6:0] STORE    = 7'h23;
    localparam logic [6:0] BRANCH   = 7'h63;
    localparam logic [6:0] JALR     = 7'h67;
    localparam logic [6:0] JAL      = 7'h6f;
    localparam logic [6:0] AUIPC    = 7'h17;
    localparam logic [6:0] LUI      = 7'h37;

    // S_OUT holds the final word of a request, S_LI1 holds the LUI half of a
    // two-word LI while the ADDIW half waits in a side register.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OUT  = 2'd1,
        S_LI1  = 2'd2
    } state_e;

    // A value sign-fits in 'bits' bits when everything from bit bits-1 upward
    // is a copy of the sign, i.e. the arithmetic shift leaves all-0 or all-1.
    function automatic logic fits_signed(input logic [63:0] v,
                                         input int unsigned bits);
        logic [63:0] upper;
        upper = $signed(v) >>> (bits - 32'd1);
        return (upper == 64'd0) || (upper == {64{1'b1}});
    endfunction

endpackage

// File: rtl/imm_pack.sv
// -----------------------------------------------------------------------------
// imm_pack
// Purely combinational immediate scatter and range check.
//   kind      : immediate format (imm_kind_e encoding, 6/7 illegal)
//   tmpl      : instruction template; immediate bit positions are replaced.
//               For LI only tmpl[11:7] (rd) is used.
//   imm       : signed immediate, DATA_WIDTH bits
//   word0     : first (or only) instruction word
//   word1     : second word, meaningful only when two_words=1 (ADDIW of LI)
//   two_words : LI needs LUI followed by ADDIW
//   err       : range / alignment violation or illegal kind. The word is
//               still built from the truncated immediate bits.
// -----------------------------------------------------------------------------
module imm_pack
    import imm_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [2:0]            kind,
    input  logic [31:0]           tmpl,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic [31:0]           word0,
    output logic [31:0]           word1,
    output logic                  two_words,
    output logic                  err
);

    logic [63:0] imm64_s;
    logic [11:0] lo12_s;
    logic [19:0] hi20_s;
    logic [4:0]  rd_s;
    logic [31:0] li_addi_s;
    logic [31:0] li_lui_s;
    logic [31:0] li_addiw_s;

    // Sign-extend the request so every range check works on 64 bits.
    assign imm64_s = 64'($signed(imm));

    assign lo12_s = imm64_s[11:0];
    // (imm[31:0] + 0x800)[31:12]: the carry out of the low 12 bits is exactly
    // imm[11], so the upper field is imm[31:12] plus that bit, wrapping in
    // 20 bits. This rounds hi20 so the sign-extended lo12 lands on the value.
    assign hi20_s = imm64_s[31:12] + {19'd0, imm64_s[11]};
    assign rd_s   = tmpl[11:7];

    assign li_addi_s  = {lo12_s, 5'd0, 3'd0, rd_s, OP_IMM};
    assign li_lui_s   = {hi20_s, rd_s, LUI};
    assign li_addiw_s = {lo12_s, rd_s, 3'd0, rd_s, OP_IMM32};

    // Format-specific scatter and checks.
    always_comb begin
        word0     = tmpl;
        word1     = 32'd0;
        two_words = 1'b0;
        err       = 1'b0;
        case (kind)
            IMM_I: begin
                word0 = {imm64_s[11:0], tmpl[19:0]};
                err   = ~fits_signed(imm64_s, 32'd12);
            end
            IMM_S: begin
                word0 = {imm64_s[11:5], tmpl[24:12], imm64_s[4:0], tmpl[6:0]};
                err   = ~fits_signed(imm64_s, 32'd12);
            end
            IMM_B: begin
                word0 = {imm64_s[12], imm64_s[10:5], tmpl[24:12],
                         imm64_s[4:1], imm64_s[11], tmpl[6:0]};
                err   = ~fits_signed(imm64_s, 32'd13) | imm64_s[0];
            end
            IMM_J: begin
                word0 = {imm64_s[20], imm64_s[10:1], imm64_s[11],
                         imm64_s[19:12], tmpl[11:0]};
                err   = ~fits_signed(imm64_s, 32'd21) | imm64_s[0];
            end
            IMM_U: begin
                word0 = {imm64_s[31:12], tmpl[11:0]};
                err   = ~fits_signed(imm64_s, 32'd32) | (imm64_s[11:0] != 12'd0);
            end
            IMM_LI: begin
                err = ~fits_signed(imm64_s, 32'd32);
                if (hi20_s == 20'd0) begin
                    // Small constant: a single ADDI from x0 reaches it.
                    word0     = li_addi_s;
                    word1     = 32'd0;
                    two_words = 1'b0;
                end else if (lo12_s == 12'd0) begin
                    // Page-aligned constant: LUI alone is exact.
                    word0     = li_lui_s;
                    word1     = 32'd0;
                    two_words = 1'b0;
                end else begin
                    // ADDIW (not ADDI) keeps the RV64 result a sign-extended
                    // 32-bit value even when LUI+lo12 crosses bit 31.
                    word0     = li_lui_s;
                    word1     = li_addiw_s;
                    two_words = 1'b1;
                end
            end
            default: begin
                // Illegal kind: pass the template through untouched.
                word0 = tmpl;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
// Packs a signed immediate into an RV64I instruction template (or expands an
// LI request into ADDI / LUI / LUI+ADDIW) and streams the words out through a
// registered valid/ready port.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   req_valid_i/ready_o : request handshake; ready is combinational from
//                         inst_ready_i so single-word requests flow at 1/cycle
//   req_kind_i          : imm_kind_e format, 6/7 illegal
//   req_tmpl_i          : instruction template
//   req_imm_i           : signed immediate
//   inst_valid_o/ready_i: output word handshake
//   inst_o              : encoded instruction word
//   inst_last_o         : final word of the current request
//   err_o               : request failed its range/alignment check
// Words are visible the cycle after the accepting edge and hold stable while
// the consumer stalls.
// -----------------------------------------------------------------------------
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [2:0]            req_kind_i,
    input  logic [31:0]           req_tmpl_i,
    input  logic [DATA_WIDTH-1:0] req_imm_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [31:0]           inst_o,
    output logic                  inst_last_o,
    output logic                  err_o
);

    state_e      state_r;
    logic        valid_r;
    logic [31:0] inst_r;
    logic        last_r;
    logic        err_r;
    logic [31:0] pend_word_r;

    logic [31:0] word0_s;
    logic [31:0] word1_s;
    logic        two_words_s;
    logic        err_s;
    logic        accept_s;
    logic        handshake_s;

    imm_pack #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pack (
        .kind      (req_kind_i),
        .tmpl      (req_tmpl_i),
        .imm       (req_imm_i),
        .word0     (word0_s),
        .word1     (word1_s),
        .two_words (two_words_s),
        .err       (err_s)
    );

    // A new request may enter when the output is empty or its final word is
    // leaving this cycle; never while the ADDIW half of an LI is pending.
    assign req_ready_o = (state_r == S_IDLE) |
                         ((state_r == S_OUT) & inst_ready_i);
    assign accept_s    = req_valid_i & req_ready_o;
    assign handshake_s = valid_r & inst_ready_i;

    assign inst_valid_o = valid_r;
    assign inst_o       = inst_r;
    assign inst_last_o  = last_r;
    assign err_o        = err_r;

    // Output FSM: loads packed words, holds them under backpressure and
    // steps from the LUI half to the ADDIW half of a two-word LI.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= S_IDLE;
            valid_r     <= 1'b0;
            inst_r      <= 32'd0;
            last_r      <= 1'b0;
            err_r       <= 1'b0;
            pend_word_r <= 32'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        valid_r     <= 1'b1;
                        inst_r      <= word0_s;
                        err_r       <= err_s;
                        last_r      <= ~two_words_s;
                        pend_word_r <= word1_s;
                        state_r     <= two_words_s ? S_LI1 : S_OUT;
                    end
                end
                S_OUT: begin
                    if (handshake_s) begin
                        if (accept_s) begin
                            valid_r     <= 1'b1;
                            inst_r      <= word0_s;
                            err_r       <= err_s;
                            last_r      <= ~two_words_s;
                            pend_word_r <= word1_s;
                            state_r     <= two_words_s ? S_LI1 : S_OUT;
                        end else begin
                            valid_r <= 1'b0;
                            inst_r  <= 32'd0;
                            last_r  <= 1'b0;
                            err_r   <= 1'b0;
                            state_r <= S_IDLE;
                        end
                    end
                end
                S_LI1: begin
                    // err_r already describes the whole LI request; keep it.
                    if (handshake_s) begin
                        inst_r  <= pend_word_r;
                        last_r  <= 1'b1;
                        state_r <= S_OUT;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    inst_r  <= 32'd0;
                    last_r  <= 1'b0;
                    err_r   <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// -----------------------------------------------------------------------------
// tb_imm_encoder
// Directed cases for the listed encodings, backpressure and reset, followed
// by randomized traffic scored against a reference model. The model builds
// expected words from field masks and range arithmetic; accepted DUT words
// are also decoded back to an immediate (LI words are executed) and compared
// with the requested value.
// -----------------------------------------------------------------------------
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_kind_i;
    logic [31:0] req_tmpl_i;
    logic [63:0] req_imm_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic        inst_last_o;
    logic        err_o;

    always #5 clk = ~clk;

    imm_encoder #(
        .DATA_WIDTH (64)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_kind_i   (req_kind_i),
        .req_tmpl_i   (req_tmpl_i),
        .req_imm_i    (req_imm_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .inst_last_o  (inst_last_o),
        .err_o        (err_o)
    );

    typedef struct {
        logic [31:0] w;
        logic        last;
        logic        err;
        logic [2:0]  kind;
        logic [63:0] val;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    bit          hold_prev = 1'b0;
    logic [31:0] prev_word;
    logic [1:0]  prev_flags;
    logic [63:0] li_acc = 64'd0;
    bit          acc_flag;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit fits(input longint sv, input int n);
        longint lim;
        lim = 64'sd1 <<< (n - 1);
        return (sv >= -lim) && (sv < lim);
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    // Recover the immediate an instruction decoder would see.
    function automatic logic [63:0] imm_dec(input logic [2:0] k, input logic [31:0] w);
        case (k)
            3'd0:    return {{52{w[31]}}, w[31:20]};
            3'd1:    return {{52{w[31]}}, w[31:25], w[11:7]};
            3'd2:    return {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd3:    return {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            3'd4:    return sext32({w[31:12], 12'd0});
            default: return 64'd0;
        endcase
    endfunction

    // Reference model: expected words for one accepted request.
    task automatic model_push(input logic [2:0] k, input logic [31:0] t,
                              input logic [63:0] v);
        exp_t        e;
        longint      sv;
        logic [31:0] sum;
        logic [19:0] hi;
        logic [11:0] lo;
        logic [4:0]  rd;
        sv     = longint'(v);
        e.kind = k;
        e.val  = v;
        e.last = 1'b1;
        e.err  = 1'b0;
        case (k)
            3'd0: begin
                e.w   = (t & 32'h000f_ffff) | {v[11:0], 20'd0};
                e.err = !fits(sv, 12);
            end
            3'd1: begin
                e.w   = (t & 32'h01ff_f07f) | {v[11:5], 25'd0} | {20'd0, v[4:0], 7'd0};
                e.err = !fits(sv, 12);
            end
            3'd2: begin
                e.w        = t & 32'h01ff_f07f;
                e.w[31]    = v[12];
                e.w[30:25] = v[10:5];
                e.w[11:8]  = v[4:1];
                e.w[7]     = v[11];
                e.err      = !fits(sv, 13) || v[0];
            end
            3'd3: begin
                e.w        = t & 32'h0000_0fff;
                e.w[31]    = v[20];
                e.w[30:21] = v[10:1];
                e.w[20]    = v[11];
                e.w[19:12] = v[19:12];
                e.err      = !fits(sv, 21) || v[0];
            end
            3'd4: begin
                e.w   = (t & 32'h0000_0fff) | {v[31:12], 12'd0};
                e.err = !fits(sv, 32) || (v[11:0] != 12'd0);
            end
            3'd5: begin
                rd    = t[11:7];
                sum   = v[31:0] + 32'h0000_0800;
                hi    = sum[31:12];
                lo    = v[11:0];
                e.err = !fits(sv, 32);
                e.val = sext32(v[31:0]);
                if (hi == 20'd0) begin
                    e.w = {lo, 5'd0, 3'd0, rd, 7'h13};
                end else if (lo == 12'd0) begin
                    e.w = {hi, rd, 7'h37};
                end else begin
                    e.w    = {hi, rd, 7'h37};
                    e.last = 1'b0;
                    sbq.push_back(e);
                    e.w    = {lo, rd, 3'd0, rd, 7'h1b};
                    e.last = 1'b1;
                end
            end
            default: begin
                e.w   = t;
                e.err = 1'b1;
            end
        endcase
        sbq.push_back(e);
    endtask

    // Execute one LI word on a single architectural register.
    task automatic li_exec(input logic [31:0] w);
        logic [31:0] r32;
        case (w[6:0])
            7'h37: li_acc = sext32({w[31:12], 12'd0});
            7'h13: li_acc = {{52{w[31]}}, w[31:20]};
            7'h1b: begin
                r32    = li_acc[31:0] + {{20{w[31]}}, w[31:20]};
                li_acc = sext32(r32);
            end
            default: li_acc = 64'hdead_dead_dead_dead;
        endcase
    endtask

    // Sampled at the falling edge: inputs are what the next rising edge sees.
    task automatic monitor();
        exp_t e;
        if (rst_i) begin
            sbq.delete();
            hold_prev = 1'b0;
            return;
        end
        if (hold_prev) begin
            check_eq("hold_valid", 64'(inst_valid_o), 64'd1);
            check_eq("hold_word", 64'(inst_o), 64'(prev_word));
            check_eq("hold_flags", 64'({inst_last_o, err_o}), 64'(prev_flags));
        end
        hold_prev  = inst_valid_o && !inst_ready_i;
        prev_word  = inst_o;
        prev_flags = {inst_last_o, err_o};
        check_eq("ready", 64'(req_ready_o),
                 64'(!inst_valid_o || (inst_ready_i && inst_last_o)));
        check_eq("valid_vs_sb", 64'(inst_valid_o), 64'(sbq.size() != 0));
        if (inst_valid_o && inst_ready_i) begin
            if (sbq.size() == 0) begin
                check_eq("sb_empty", 64'(sbq.size()), 64'd1);
            end else begin
                e = sbq.pop_front();
                check_eq("word", 64'(inst_o), 64'(e.w));
                check_eq("last", 64'(inst_last_o), 64'(e.last));
                check_eq("err", 64'(err_o), 64'(e.err));
                if (e.kind == 3'd5) begin
                    li_exec(inst_o);
                    if (e.last && !e.err) check_eq("li_dec", li_acc, e.val);
                end else if (e.kind < 3'd5 && !e.err) begin
                    check_eq("imm_dec", imm_dec(e.kind, inst_o), e.val);
                end
            end
        end
        if (req_valid_i && req_ready_o) begin
            model_push(req_kind_i, req_tmpl_i, req_imm_i);
            acc_flag = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] k, input logic [31:0] t, input logic [63:0] v);
        req_valid_i = 1'b1;
        req_kind_i  = k;
        req_tmpl_i  = t;
        req_imm_i   = v;
        acc_flag    = 1'b0;
        for (int i = 0; i < 20 && !acc_flag; i++) tick();
        req_valid_i = 1'b0;
        check_eq("accept", 64'(acc_flag), 64'd1);
    endtask

    function automatic logic [63:0] rand_imm();
        logic [63:0] b;
        logic [31:0] x;
        int          n;
        x = $urandom();
        case ($urandom_range(0, 4))
            0: return {$urandom(), $urandom()};
            1: return 64'($urandom_range(0, 8191)) - 64'd4096;
            2: begin
                case ($urandom_range(0, 3))
                    0:       n = 12;
                    1:       n = 13;
                    2:       n = 21;
                    default: n = 32;
                endcase
                b = 64'd1 << (n - 1);
                case ($urandom_range(0, 3))
                    0:       return b;
                    1:       return b - 64'd1;
                    2:       return -b;
                    default: return -b - 64'd1;
                endcase
            end
            3: return sext32({x[31:12], 12'd0});
            default: return sext32(x);
        endcase
    endfunction

    initial begin
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_kind_i   = 3'd0;
        req_tmpl_i   = 32'd0;
        req_imm_i    = 64'd0;
        inst_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        check_eq("rst_valid", 64'(inst_valid_o), 64'd0);
        check_eq("rst_inst", 64'(inst_o), 64'd0);
        check_eq("rst_last", 64'(inst_last_o), 64'd0);
        check_eq("rst_err", 64'(err_o), 64'd0);
        check_eq("rst_ready", 64'(req_ready_o), 64'd1);

        // I-type, imm=-1
        send(3'd0, 32'h0000_0013, 64'hffff_ffff_ffff_ffff);
        check_eq("i_word", 64'(inst_o), 64'h0000_0000_fff0_0013);
        check_eq("i_err", 64'(err_o), 64'd0);
        check_eq("i_last", 64'(inst_last_o), 64'd1);
        check_eq("i_valid", 64'(inst_valid_o), 64'd1);
        tick();

        // B-type, most negative offset, then an odd offset
        send(3'd2, 32'h0000_0063, 64'hffff_ffff_ffff_f000);
        check_eq("b_word", 64'(inst_o), 64'h0000_0000_8000_0063);
        check_eq("b_err", 64'(err_o), 64'd0);
        tick();
        send(3'd2, 32'h0000_0063, 64'd3);
        check_eq("b_odd_err", 64'(err_o), 64'd1);
        tick();

        // Two-word LI, rd=x5
        send(3'd5, 32'h0000_0280, 64'h0000_0000_7fff_f800);
        check_eq("li_lui", 64'(inst_o), 64'h0000_0000_8000_02b7);
        check_eq("li_lui_last", 64'(inst_last_o), 64'd0);
        check_eq("li1_ready", 64'(req_ready_o), 64'd0);
        tick();
        check_eq("li_addiw", 64'(inst_o), 64'h0000_0000_8002_829b);
        check_eq("li_addiw_last", 64'(inst_last_o), 64'd1);
        tick();
        check_eq("li_golden", li_acc, 64'h0000_0000_7fff_f800);

        // Single-word LI forms, rd=x1
        send(3'd5, 32'h0000_0080, 64'd5);
        check_eq("li_addi", 64'(inst_o), 64'h0000_0000_0050_0093);
        check_eq("li_addi_last", 64'(inst_last_o), 64'd1);
        tick();
        send(3'd5, 32'h0000_0080, 64'h0000_0000_1234_5000);
        check_eq("li_lui_only", 64'(inst_o), 64'h0000_0000_1234_50b7);
        check_eq("li_lui_only_last", 64'(inst_last_o), 64'd1);
        tick();

        // Backpressure in the LUI half
        inst_ready_i = 1'b0;
        send(3'd5, 32'h0000_0280, 64'h0000_0000_7fff_f800);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_word", 64'(inst_o), 64'h0000_0000_8000_02b7);
            check_eq("bp_ready", 64'(req_ready_o), 64'd0);
            check_eq("bp_valid", 64'(inst_valid_o), 64'd1);
        end
        inst_ready_i = 1'b1;
        tick();
        check_eq("bp_addiw", 64'(inst_o), 64'h0000_0000_8002_829b);
        check_eq("bp_addiw_last", 64'(inst_last_o), 64'd1);
        tick();

        // Reset while the ADDIW half is pending
        inst_ready_i = 1'b0;
        send(3'd5, 32'h0000_0280, 64'h0000_0000_7fff_f800);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_eq("rst_li_valid", 64'(inst_valid_o), 64'd0);
        check_eq("rst_li_ready", 64'(req_ready_o), 64'd1);
        inst_ready_i = 1'b1;
        repeat (3) tick();
        check_eq("rst_no_addiw", 64'(inst_valid_o), 64'd0);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            req_valid_i  = ($urandom_range(0, 9) < 6);
            req_kind_i   = 3'($urandom_range(0, 7));
            req_tmpl_i   = $urandom();
            req_imm_i    = rand_imm();
            inst_ready_i = ($urandom_range(0, 9) < 7);
            rst_i        = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst_i        = 1'b0;
        req_valid_i  = 1'b0;
        inst_ready_i = 1'b1;
        repeat (5) tick();
        check_eq("drain", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
